// File: rtl/counter_pkg.sv
// Shared definitions for the down_counter timer: state encoding and default width.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter/timer with pause, stop and a one-cycle done pulse.
// Optional feature: define AUTO_RELOAD_EN for periodic reload from a captured start value.
module down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] eff_value;

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Start value seen by an IDLE start: a simultaneous load takes precedence.
  assign eff_value = load ? load_value : count_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          count_d  = load_value;
`ifdef AUTO_RELOAD_EN
          reload_d = load_value;
`endif
        end
        if (start) begin
          state_d = (eff_value != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_HOLD;
        end else if (count_q <= WIDTH'(1)) begin
          count_d = '0;
          state_d = ST_DONE;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      ST_HOLD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
`ifdef AUTO_RELOAD_EN
        if (stop || (reload_q == '0)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
          count_d = reload_q;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
`ifdef AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
`ifdef AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count = count_q;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter (default build, AUTO_RELOAD_EN optional).
module tb_down_counter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         load, start, pause, stop;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         busy, done;

  int total = 0;
  int bad   = 0;
  int done_cnt;

  down_counter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .stop(stop),
    .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    load = 0; start = 0; pause = 0; stop = 0;
  endtask

  task automatic kick(input int v);
    load_value = W'(v); load = 1; start = 1;
    tick();
    load = 0; start = 0;
  endtask

  initial begin
    idle_inputs();
    load_value = '0;
    reset = 1;
    #10;
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    reset = 0;

    // 1: load+start 5 counts 5..1 then 0 with done
    kick(5);
    for (int e = 5; e >= 1; e--) begin
      chk("t1_count", int'(count), e);
      chk("t1_busy", int'(busy), 1);
      chk("t1_done", int'(done), 0);
      tick();
    end
    chk("t1_zero", int'(count), 0);
    chk("t1_done_hi", int'(done), 1);
    chk("t1_busy_lo", int'(busy), 0);
    tick();
    chk("t1_done_lo", int'(done), 0);
    chk("t1_idle_busy", int'(busy), 0);
    chk("t1_idle_count", int'(count), 0);

    // 2: pause at 3 for three edges
    kick(6);
    tick(); tick(); tick();
    chk("t2_at3", int'(count), 3);
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_count", int'(count), 3);
      chk("t2_hold_busy", int'(busy), 1);
    end
    pause = 0;
    tick();
    chk("t2_resume", int'(count), 3);
    done_cnt = 0;
    for (int e = 2; e >= 0; e--) begin
      tick();
      chk("t2_count", int'(count), e);
      if (done) done_cnt++;
    end
    tick();
    if (done) done_cnt++;
    chk("t2_done_pulses", done_cnt, 1);

    // 3: stop at 4, then restart
    kick(9);
    for (int i = 0; i < 5; i++) tick();
    chk("t3_at4", int'(count), 4);
    stop = 1;
    tick();
    stop = 0;
    chk("t3_stop_count", int'(count), 4);
    chk("t3_stop_busy", int'(busy), 0);
    chk("t3_stop_done", int'(done), 0);
    tick();
    chk("t3_idle_hold", int'(count), 4);
    chk("t3_no_done", int'(done), 0);
    start = 1;
    tick();
    start = 0;
    chk("t3_restart", int'(count), 4);
    for (int e = 3; e >= 0; e--) begin
      tick();
      chk("t3_count", int'(count), e);
    end
    chk("t3_done", int'(done), 1);
    tick();

    // 4: zero-length timer, then load/start ignored in RUN
    kick(0);
    chk("t4_done", int'(done), 1);
    chk("t4_busy", int'(busy), 0);
    chk("t4_count", int'(count), 0);
    tick();
    chk("t4_done_lo", int'(done), 0);
    chk("t4_busy_lo", int'(busy), 0);
    kick(5);
    chk("t4_run5", int'(count), 5);
    load_value = W'(12); load = 1; start = 1;
    tick();
    idle_inputs();
    chk("t4_ignore", int'(count), 4);
    tick();
    chk("t4_cont", int'(count), 3);
    stop = 1; tick(); stop = 0;

    // 5: asynchronous reset mid-run
    kick(10);
    tick(); tick(); tick();
    chk("t5_at7", int'(count), 7);
    #2 reset = 1;
    #1;
    chk("t5_rst_count", int'(count), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_done", int'(done), 0);
    @(negedge clk);
    reset = 0;

`ifdef AUTO_RELOAD_EN
    // 6: periodic reload
    kick(3);
    for (int r = 0; r < 2; r++) begin
      for (int e = 3; e >= 1; e--) begin
        chk("t6_count", int'(count), e);
        chk("t6_done_lo", int'(done), 0);
        tick();
      end
      chk("t6_zero", int'(count), 0);
      chk("t6_done_hi", int'(done), 1);
      tick();
    end
    chk("t6_reload", int'(count), 3);
    stop = 1; tick(); stop = 0;
    chk("t6_stop_busy", int'(busy), 0);
    tick();
    chk("t6_stay_idle", int'(busy), 0);
`else
    // 6: without reload, DONE returns to IDLE and stays there
    kick(3);
    tick(); tick(); tick();
    chk("t6_done_hi", int'(done), 1);
    tick(); tick();
    chk("t6_no_reload", int'(count), 0);
    chk("t6_idle_busy", int'(busy), 0);
    chk("t6_idle_done", int'(done), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
